// File: rtl/reg_writeback_arbiter_pkg.sv
// Shared types and constants for the register-file write-side arbiter.
// Covers the entry format, the source-select encoding and the scoreboard decode helper.
package reg_writeback_arbiter_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int DEPTH      = 2;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_LONG = 2'd2
    } src_sel_e;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
        logic [NUM_REGS-1:0] vec;
        vec     = {NUM_REGS{1'b0}};
        vec[rd] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/reg_writeback_arbiter_fifo.sv
// Two-entry buffer for long-latency results waiting for the register-file port.
// The occupancy state doubles as the entry count.
module wb_fifo2
    import reg_writeback_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  wb_entry_t  push_entry,
    input  logic       pop,
    output wb_entry_t  head_entry,
    output logic [1:0] count,
    output logic       full,
    output logic       empty
);

    fifo_state_e state_q, state_d;
    wb_entry_t   mem_q [DEPTH];
    wb_entry_t   mem_d [DEPTH];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        push_ok_s;
    logic        pop_ok_s;

    // Occupancy, pointer and storage next-state
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        push_ok_s = push && (state_q != FIFO_FULL);
        pop_ok_s  = pop && (state_q != FIFO_EMPTY);
        wr_ptr_d  = wr_ptr_q ^ push_ok_s;
        rd_ptr_d  = rd_ptr_q ^ pop_ok_s;
        if (push_ok_s) begin
            mem_d[wr_ptr_q] = push_entry;
        end else begin
            mem_d = mem_q;
        end
        case (state_q)
            FIFO_EMPTY: begin
                if (push_ok_s) state_d = FIFO_ONE;
                else           state_d = FIFO_EMPTY;
            end
            FIFO_ONE: begin
                if (push_ok_s && !pop_ok_s)      state_d = FIFO_FULL;
                else if (pop_ok_s && !push_ok_s) state_d = FIFO_EMPTY;
                else                             state_d = FIFO_ONE;
            end
            FIFO_FULL: begin
                if (pop_ok_s) state_d = FIFO_ONE;
                else          state_d = FIFO_FULL;
            end
            default: state_d = FIFO_EMPTY;
        endcase
    end

    // State registers; reset drops any buffered entries
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= FIFO_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = state_q;
    assign full       = (state_q == FIFO_FULL);
    assign empty      = (state_q == FIFO_EMPTY);

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges pipeline writebacks and mul/div results onto the single register-file write port.
// Also keeps the pending-destination scoreboard that decode consults for RAW stalls.
module reg_writeback_arbiter
    import reg_writeback_arbiter_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  PIPE_WEN,
    input  logic [REG_ADDR_W-1:0] PIPE_RD,
    input  logic [XLEN-1:0]       PIPE_DATA,
    input  logic                  LONG_ISSUE,
    input  logic [REG_ADDR_W-1:0] LONG_ISSUE_RD,
    input  logic                  LONG_VALID,
    input  logic [REG_ADDR_W-1:0] LONG_RD,
    input  logic [XLEN-1:0]       LONG_DATA,
    output logic                  LONG_READY,
    output logic [XLEN-1:0]       RF_IN,
    output logic [REG_ADDR_W-1:0] RF_INADDRESS,
    output logic                  RF_WRITE,
    input  logic [REG_ADDR_W-1:0] CHK1ADDR,
    input  logic [REG_ADDR_W-1:0] CHK2ADDR,
    output logic                  CHK1_PENDING,
    output logic                  CHK2_PENDING,
    output logic                  BUSY
);

    src_sel_e              sel_s;
    wb_entry_t             long_entry_s, head_entry_s, win_entry_s;
    logic                  pipe_eff_s, long_wr_s, push_s, pop_s;
    logic [1:0]            fifo_count_s;
    logic                  fifo_full_s, fifo_empty_s;
    logic                  ready_en_q, ready_en_d;
    logic                  rf_write_q, rf_write_d;
    logic [REG_ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [XLEN-1:0]       rf_data_q, rf_data_d;
    logic                  out_long_q, out_long_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;
    logic [NUM_REGS-1:0]   set_vec_s, clr_vec_s;

    assign long_entry_s.rd   = LONG_RD;
    assign long_entry_s.data = LONG_DATA;

    wb_fifo2 u_fifo (
        .clk        (CLK),
        .rst        (RESET),
        .push       (push_s),
        .push_entry (long_entry_s),
        .pop        (pop_s),
        .head_entry (head_entry_s),
        .count      (fifo_count_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    // Port arbitration: pipe first, then FIFO head, then bypass of a fresh long result
    always_comb begin
        pipe_eff_s  = PIPE_WEN && (PIPE_RD != 5'd0);
        long_wr_s   = LONG_VALID && LONG_READY && (LONG_RD != 5'd0);
        push_s      = 1'b0;
        pop_s       = 1'b0;
        sel_s       = SRC_NONE;
        win_entry_s = long_entry_s;
        if (pipe_eff_s) begin
            sel_s              = SRC_PIPE;
            win_entry_s.rd     = PIPE_RD;
            win_entry_s.data   = PIPE_DATA;
            push_s             = long_wr_s;
        end else if (!fifo_empty_s) begin
            sel_s       = SRC_LONG;
            win_entry_s = head_entry_s;
            pop_s       = 1'b1;
            push_s      = long_wr_s;
        end else if (long_wr_s) begin
            sel_s       = SRC_LONG;
            win_entry_s = long_entry_s;
        end else begin
            sel_s       = SRC_NONE;
        end
    end

    // Output register and scoreboard next-state; an issue beats a same-cycle completion
    always_comb begin
        ready_en_d = 1'b1;
        rf_write_d = (sel_s != SRC_NONE);
        out_long_d = (sel_s == SRC_LONG);
        rf_addr_d  = rf_addr_q;
        rf_data_d  = rf_data_q;
        if (sel_s != SRC_NONE) begin
            rf_addr_d = win_entry_s.rd;
            rf_data_d = win_entry_s.data;
        end else begin
            rf_addr_d = rf_addr_q;
            rf_data_d = rf_data_q;
        end
        if (sel_s == SRC_LONG) clr_vec_s = rd_onehot(win_entry_s.rd);
        else                   clr_vec_s = {NUM_REGS{1'b0}};
        if (LONG_ISSUE && (LONG_ISSUE_RD != 5'd0)) set_vec_s = rd_onehot(LONG_ISSUE_RD);
        else                                       set_vec_s = {NUM_REGS{1'b0}};
        pending_d = (pending_q & ~clr_vec_s) | set_vec_s;
    end

    // Registered RF port, scoreboard and post-reset ready enable
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ready_en_q <= 1'b0;
            rf_write_q <= 1'b0;
            rf_addr_q  <= 5'd0;
            rf_data_q  <= 32'd0;
            out_long_q <= 1'b0;
            pending_q  <= {NUM_REGS{1'b0}};
        end else begin
            ready_en_q <= ready_en_d;
            rf_write_q <= rf_write_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
            out_long_q <= out_long_d;
            pending_q  <= pending_d;
        end
    end

    assign LONG_READY   = ready_en_q && !fifo_full_s;
    assign RF_WRITE     = rf_write_q;
    assign RF_INADDRESS = rf_addr_q;
    assign RF_IN        = rf_data_q;
    assign BUSY         = (fifo_count_s != 2'd0) || out_long_q;
    assign CHK1_PENDING = (CHK1ADDR != 5'd0) && pending_q[CHK1ADDR];
    assign CHK2_PENDING = (CHK2ADDR != 5'd0) && pending_q[CHK2ADDR];

endmodule

// File: tb/tb_reg_writeback_arbiter.sv
// Directed bench for reg_writeback_arbiter with a behavioural register file on the RF port.
module tb_reg_writeback_arbiter;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        PIPE_WEN;
    logic [4:0]  PIPE_RD;
    logic [31:0] PIPE_DATA;
    logic        LONG_ISSUE;
    logic [4:0]  LONG_ISSUE_RD;
    logic        LONG_VALID;
    logic [4:0]  LONG_RD;
    logic [31:0] LONG_DATA;
    logic        LONG_READY;
    logic [31:0] RF_IN;
    logic [4:0]  RF_INADDRESS;
    logic        RF_WRITE;
    logic [4:0]  CHK1ADDR, CHK2ADDR;
    logic        CHK1_PENDING, CHK2_PENDING;
    logic        BUSY;

    int checks = 0;
    int errors = 0;
    logic [31:0] rf_mem [32];

    always #5 CLK = ~CLK;

    reg_writeback_arbiter dut (
        .CLK(CLK), .RESET(RESET),
        .PIPE_WEN(PIPE_WEN), .PIPE_RD(PIPE_RD), .PIPE_DATA(PIPE_DATA),
        .LONG_ISSUE(LONG_ISSUE), .LONG_ISSUE_RD(LONG_ISSUE_RD),
        .LONG_VALID(LONG_VALID), .LONG_RD(LONG_RD), .LONG_DATA(LONG_DATA),
        .LONG_READY(LONG_READY),
        .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS), .RF_WRITE(RF_WRITE),
        .CHK1ADDR(CHK1ADDR), .CHK2ADDR(CHK2ADDR),
        .CHK1_PENDING(CHK1_PENDING), .CHK2_PENDING(CHK2_PENDING),
        .BUSY(BUSY)
    );

    // Register file consuming the write port on the following edge
    always @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else if (RF_WRITE) begin
            rf_mem[RF_INADDRESS] <= RF_IN;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        PIPE_WEN = 1'b0; PIPE_RD = 5'd0; PIPE_DATA = 32'd0;
        LONG_ISSUE = 1'b0; LONG_ISSUE_RD = 5'd0;
        LONG_VALID = 1'b0; LONG_RD = 5'd0; LONG_DATA = 32'd0;
    endtask

    task automatic check_port(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
        check_eq({tag, "_write"}, {31'd0, RF_WRITE}, {31'd0, w});
        if (w) begin
            check_eq({tag, "_addr"}, {27'd0, RF_INADDRESS}, {27'd0, a});
            check_eq({tag, "_data"}, RF_IN, d);
        end
    endtask

    initial begin
        RESET = 1'b1;
        idle_inputs();
        CHK1ADDR = 5'd0; CHK2ADDR = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        check_eq("rst_write", {31'd0, RF_WRITE}, 32'd0);
        check_eq("rst_in", RF_IN, 32'd0);
        check_eq("rst_addr", {27'd0, RF_INADDRESS}, 32'd0);
        check_eq("rst_ready", {31'd0, LONG_READY}, 32'd0);
        check_eq("rst_busy", {31'd0, BUSY}, 32'd0);
        RESET = 1'b0;
        step();
        check_eq("ready_after_rst", {31'd0, LONG_READY}, 32'd1);

        // Single pipe write to x1
        PIPE_WEN = 1'b1; PIPE_RD = 5'd1; PIPE_DATA = 32'd10;
        step();
        check_port("pipe1", 1'b1, 5'd1, 32'd10);
        idle_inputs();
        step();
        check_port("pipe1_idle", 1'b0, 5'd0, 32'd0);
        check_eq("rf_x1", rf_mem[1], 32'd10);

        // Scoreboard set by issue, cleared on bypassed completion
        LONG_ISSUE = 1'b1; LONG_ISSUE_RD = 5'd5;
        step();
        idle_inputs();
        CHK1ADDR = 5'd5; CHK2ADDR = 5'd0;
        #1;
        check_eq("pend5_set", {31'd0, CHK1_PENDING}, 32'd1);
        check_eq("pend0", {31'd0, CHK2_PENDING}, 32'd0);
        LONG_VALID = 1'b1; LONG_RD = 5'd5; LONG_DATA = 32'd99;
        step();
        idle_inputs();
        check_port("bypass5", 1'b1, 5'd5, 32'd99);
        check_eq("pend5_clr", {31'd0, CHK1_PENDING}, 32'd0);
        check_eq("busy_outreg", {31'd0, BUSY}, 32'd1);
        step();
        check_eq("busy_idle", {31'd0, BUSY}, 32'd0);

        // FIFO fills behind three pipe writes, then drains in order
        PIPE_WEN = 1'b1; PIPE_RD = 5'd10; PIPE_DATA = 32'd100;
        LONG_VALID = 1'b1; LONG_RD = 5'd6; LONG_DATA = 32'd7;
        step();
        check_port("fillA", 1'b1, 5'd10, 32'd100);
        check_eq("ready_one", {31'd0, LONG_READY}, 32'd1);
        PIPE_RD = 5'd11; PIPE_DATA = 32'd101;
        LONG_RD = 5'd7; LONG_DATA = 32'd8;
        step();
        check_port("fillB", 1'b1, 5'd11, 32'd101);
        check_eq("ready_full", {31'd0, LONG_READY}, 32'd0);
        check_eq("busy_full", {31'd0, BUSY}, 32'd1);
        LONG_VALID = 1'b0;
        PIPE_RD = 5'd12; PIPE_DATA = 32'd102;
        step();
        check_port("fillC", 1'b1, 5'd12, 32'd102);
        check_eq("ready_still_full", {31'd0, LONG_READY}, 32'd0);
        idle_inputs();
        step();
        check_port("drain6", 1'b1, 5'd6, 32'd7);
        check_eq("ready_drain", {31'd0, LONG_READY}, 32'd1);
        step();
        check_port("drain7", 1'b1, 5'd7, 32'd8);
        step();
        check_port("drain_done", 1'b0, 5'd0, 32'd0);
        check_eq("busy_drained", {31'd0, BUSY}, 32'd0);

        // Pipe write to x0 yields the port to a long result
        PIPE_WEN = 1'b1; PIPE_RD = 5'd0; PIPE_DATA = 32'd55;
        LONG_VALID = 1'b1; LONG_RD = 5'd2; LONG_DATA = 32'd22;
        step();
        idle_inputs();
        check_port("x0pipe_long2", 1'b1, 5'd2, 32'd22);
        step();
        check_eq("rf_x0", rf_mem[0], 32'd0);
        check_eq("rf_x2", rf_mem[2], 32'd22);

        // Long result to x0 is swallowed
        LONG_VALID = 1'b1; LONG_RD = 5'd0; LONG_DATA = 32'd33;
        step();
        idle_inputs();
        check_port("long_x0", 1'b0, 5'd0, 32'd0);
        check_eq("long_x0_busy", {31'd0, BUSY}, 32'd0);

        // Same-cycle issue and completion on x4 leaves it pending
        LONG_ISSUE = 1'b1; LONG_ISSUE_RD = 5'd4;
        step();
        LONG_VALID = 1'b1; LONG_RD = 5'd4; LONG_DATA = 32'd44;
        step();
        idle_inputs();
        CHK2ADDR = 5'd4;
        #1;
        check_port("issue_clr4", 1'b1, 5'd4, 32'd44);
        check_eq("pend4_kept", {31'd0, CHK2_PENDING}, 32'd1);
        LONG_VALID = 1'b1; LONG_RD = 5'd4; LONG_DATA = 32'd45;
        step();
        idle_inputs();
        check_eq("pend4_clr", {31'd0, CHK2_PENDING}, 32'd0);

        // Reset while FIFO is full discards the buffered results
        step();
        PIPE_WEN = 1'b1; PIPE_RD = 5'd13; PIPE_DATA = 32'd130;
        LONG_VALID = 1'b1; LONG_RD = 5'd8; LONG_DATA = 32'd80;
        step();
        PIPE_RD = 5'd14; PIPE_DATA = 32'd140;
        LONG_RD = 5'd9; LONG_DATA = 32'd90;
        step();
        check_eq("pre_rst_full", {31'd0, LONG_READY}, 32'd0);
        idle_inputs();
        #2;
        RESET = 1'b1;
        #1;
        check_eq("midrst_write", {31'd0, RF_WRITE}, 32'd0);
        check_eq("midrst_in", RF_IN, 32'd0);
        check_eq("midrst_busy", {31'd0, BUSY}, 32'd0);
        check_eq("midrst_ready", {31'd0, LONG_READY}, 32'd0);
        step();
        step();
        RESET = 1'b0;
        step();
        check_eq("post_rst_ready", {31'd0, LONG_READY}, 32'd1);
        check_port("post_rst0", 1'b0, 5'd0, 32'd0);
        step();
        check_port("post_rst1", 1'b0, 5'd0, 32'd0);
        check_eq("post_rst_busy", {31'd0, BUSY}, 32'd0);
        step();
        check_eq("no_stale_x8", rf_mem[8], 32'd0);
        check_eq("no_stale_x9", rf_mem[9], 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
